// File: rtl/tff_counter.sv
// tff_counter: modulo-N up/down counter built from WIDTH T-type state bits.
// The next count is computed arithmetically, then turned into a toggle vector
// (t_vec = q ^ next). Each state bit only ever toggles or holds.
module tff_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 2 ** WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             wrap
);

    // Compare against MODULUS-1 in WIDTH bits. MODULUS itself may need
    // WIDTH+1 bits when it equals 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_min;
    logic             counting;

    // Terminal-count detection: tc flags that the coming edge wraps.
    always_comb begin
        at_max   = (q_q == MAX_VAL);
        at_min   = (q_q == '0);
        counting = en & ~load & ~rst;
        tc       = counting & (up ? at_max : at_min);
    end

    // Next-count selection with priority rst > load > en > hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (rst) begin
            q_d = RST_VAL;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the count range.
            q_d = (din > MAX_VAL) ? MAX_VAL : din;
        end else if (en) begin
            if (up) begin
                q_d = at_max ? '0 : q_q + ONE;
            end else begin
                q_d = at_min ? MAX_VAL : q_q - ONE;
            end
            wrap_d = tc;
        end
    end

    // Toggle vector: one T input per state bit.
    always_comb begin
        t_vec = q_q ^ q_d;
    end

    // T-type state bits plus the registered wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_q ^ t_vec;
            wrap_q <= wrap_d;
        end
    end

    // Output drive.
    always_comb begin
        q    = q_q;
        qb   = ~q_q;
        wrap = wrap_q;
    end

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: a decimal counter (WIDTH=4, MODULUS=10) and a
// single-bit T flip-flop (WIDTH=1, MODULUS=2) share one stimulus stream and
// are compared against an arithmetic reference model.
module tb_tff_counter;

    localparam int MOD_A = 10;
    localparam int RV_A  = 0;
    localparam int MOD_B = 2;
    localparam int RV_B  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;

    logic [3:0] q_a, qb_a, tv_a;
    logic       tc_a, wrap_a;
    logic [0:0] q_b, qb_b, tv_b;
    logic       tc_b, wrap_b;

    int checks = 0;
    int errors = 0;

    int  mq_a = 0;
    int  mq_b = 0;
    bit  known = 1'b0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MODULUS(MOD_A), .RESET_VAL(RV_A)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .q(q_a), .qb(qb_a), .t_vec(tv_a), .tc(tc_a), .wrap(wrap_a)
    );

    tff_counter #(.WIDTH(1), .MODULUS(MOD_B), .RESET_VAL(RV_B)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din[0:0]),
        .q(q_b), .qb(qb_b), .t_vec(tv_b), .tc(tc_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model(input int cur, input int modulus, input int rv,
                         input bit r, input bit l, input bit e, input bit u, input int d,
                         output int nxt, output bit wr);
        int s;
        wr = 1'b0;
        if (r) begin
            nxt = rv;
        end else if (l) begin
            nxt = (d < modulus) ? d : modulus - 1;
        end else if (e) begin
            s   = u ? cur + 1 : cur - 1;
            wr  = (s >= modulus) || (s < 0);
            nxt = (s + modulus) % modulus;
        end else begin
            nxt = cur;
        end
    endtask

    task automatic step(input bit r, input bit l, input bit e, input bit u, input int d);
        int  na, nb;
        bit  wa, wb;
        @(negedge clk);
        rst  = r;
        load = l;
        en   = e;
        up   = u;
        din  = 4'(d);
        #1;
        model(mq_a, MOD_A, RV_A, r, l, e, u, d, na, wa);
        model(mq_b, MOD_B, RV_B, r, l, e, u, d % 2, nb, wb);
        if (known) begin
            check("a_tc",    {31'd0, tc_a}, {31'd0, wa});
            check("a_t_vec", {28'd0, tv_a}, 32'(mq_a ^ na));
            check("b_tc",    {31'd0, tc_b}, {31'd0, wb});
            check("b_t_vec", {31'd0, tv_b}, 32'(mq_b ^ nb));
        end
        @(posedge clk);
        #1;
        mq_a  = na;
        mq_b  = nb;
        known = 1'b1;
        check("a_q",     {28'd0, q_a},  32'(mq_a));
        check("a_qb",    {28'd0, qb_a}, 32'(~mq_a & 15));
        check("a_wrap",  {31'd0, wrap_a}, {31'd0, wa});
        check("a_range", {31'd0, (q_a < 4'(MOD_A))}, 32'd1);
        check("b_q",     {31'd0, q_b},  32'(mq_b));
        check("b_qb",    {31'd0, qb_b}, 32'(~mq_b & 1));
        check("b_wrap",  {31'd0, wrap_b}, {31'd0, wb});
    endtask

    initial begin
        // reset, then count up through the decimal wrap
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
        // count down from 0: 9, 8, 7
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        // load ignores en; clamp; rst beats load
        step(0, 1, 1, 1, 6);
        step(0, 1, 1, 0, 13);
        step(1, 1, 1, 1, 7);
        // reset mid-count at q=5, then resume
        step(0, 1, 0, 0, 5);
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        // hold at 3, then alternate direction
        step(0, 1, 0, 0, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, (i % 2 == 0), 0);
        // load at the edges of the range
        step(0, 1, 0, 0, 9);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 15);
        step(0, 1, 0, 0, 10);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 int'($urandom_range(0, 15)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tff_counter.md
# tff_counter

Parametrised synchronous counter built as a bank of WIDTH T-type state bits, the next generation of the single JK/T flip-flop cells in this library. Adds a programmable modulus, up/down direction, parallel load, enable, synchronous reset, terminal-count and wrap indication. Used wherever a divide-by-N, modulo event counter or cycle timer is needed.

## Interface
- WIDTH, 4, number of state bits (1..16)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal 2..2**WIDTH
- RESET_VAL, 0, value loaded by reset; must be < MODULUS

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- din  input  WIDTH  parallel load value
- q  output  WIDTH  current count
- qb  output  WIDTH  bitwise complement of q, always ~q
- t_vec  output  WIDTH  toggle vector applied at the next edge, combinational
- tc  output  1  terminal count, combinational
- wrap  output  1  registered one-cycle pulse after a wrap

## Operation
- State: WIDTH T-type bits. Each bit toggles when its t_vec bit is 1, else holds. t_vec = q ^ next, so one bit per T cell; no other state update path.
- Priority at each edge: rst > load > en > hold.
- rst=1: q <= RESET_VAL, wrap <= 0. Overrides load and en, including mid-count.
- load=1 (rst=0): q <= din if din < MODULUS, else q <= MODULUS-1 (clamp). Load ignores en and up. wrap <= 0.
- en=1, load=0, up=1: q <= q+1; if q == MODULUS-1, q <= 0 and wrap <= 1.
- en=1, load=0, up=0: q <= q-1; if q == 0, q <= MODULUS-1 and wrap <= 1.
- en=0, load=0: q holds, t_vec = 0, wrap <= 0.
- wrap is 0 on every edge not listed as setting it.
- tc = en & ~load & ~rst & (up ? q == MODULUS-1 : q == 0). tc high means the next edge wraps.
- Arithmetic modulo MODULUS, not 2**WIDTH. No out-of-range value (>= MODULUS) ever appears on q after reset.
- Direction change on any cycle takes effect at the next edge. No extra latency, no glitch state.
- MODULUS == 2**WIDTH: compare logic reduces to natural binary wrap. Behaviour is identical.
- WIDTH=1, MODULUS=2, en=1: the block behaves as a plain T flip-flop with t = en.

## Timing
- Reset values: q = RESET_VAL, qb = ~RESET_VAL, wrap = 0. t_vec and tc follow inputs combinationally.
- Count, load and reset latency is 1 cycle: the value is visible on q after the capturing edge.
- wrap is asserted in the same cycle that q shows the wrapped value, for exactly one cycle per wrap.
- tc and t_vec are valid in the same cycle as their inputs. Inputs are sampled only at the rising edge.
- Back-to-back wraps at MODULUS=2 with en held high: wrap is high every other cycle.

## Test plan
- WIDTH=4, MODULUS=10, RESET_VAL=0, rst 1 cycle then en=1, up=1 for 12 cycles -> q goes 0,1..9,0,1. tc is high while q=9. wrap is high only in the cycle q=0 after 9. qb = ~q throughout.
- Same configuration, up=0 from q=0 -> q goes 9,8,7. wrap is high in the cycle q=9. tc is high while q=0 and en=1.
- load=1, din=6, with en=1 -> next q=6, no count that cycle. Then load din=13 -> q=9 (clamp). load and rst together -> q=RESET_VAL.
- At q=5 with en=1, assert rst for 1 cycle -> q=0 next edge, wrap=0. Count resumes from 0 on the following edge.
- en=0 for 5 cycles at q=3 -> q stays 3, t_vec=0, tc=0. Toggle up/down each cycle with en=1 from q=3 -> 4,3,4,3. t_vec equals q^next every cycle.
- WIDTH=1, MODULUS=2, en=1 for 4 cycles -> q goes 0,1,0,1. wrap is high on each return to 0.
